// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP32 constants, arbiter state encoding and field helper
package fp_pkg;

    localparam int          FP32_W    = 32;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESP    = 3'd3,
        ST_RECOVER = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] mant;
    } fp32_fields_t;

    function automatic fp32_fields_t fp32_fields(input logic [FP32_W-1:0] x);
        fp32_fields_t f;
        f.sign = x[31];
        f.exp  = x[30:23];
        f.mant = x[22:0];
        return f;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker starting at rr_ptr
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        win_idx    = '0;
        any        = 1'b0;
        sum        = '0;
        cand       = '0;
        win_onehot = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(N_REQ)) begin
                sum = sum - (IDX_W + 1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (req[cand]) begin
                win_idx = cand;
                any     = 1'b1;
            end
        end
        if (any) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fpmul_rr_arbiter.sv
// rtl/fpmul_rr_arbiter.sv - round-robin sharing of one FP32 multiplier with watchdog
module fpmul_rr_arbiter
    import fp_pkg::*;
#(
    parameter int          N_REQ    = 4,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] QNAN_VAL = FP32_QNAN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [FP32_W*N_REQ-1:0]   op1_in,
    input  logic [FP32_W*N_REQ-1:0]   op2_in,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          resp_valid,
    output logic [FP32_W-1:0]         resp_res,
    output logic                      resp_err,
    output logic                      busy,
    output logic                      mul_ready,
    output logic [FP32_W-1:0]         mul_op1,
    output logic [FP32_W-1:0]         mul_op2,
    input  logic [FP32_W-1:0]         mul_res,
    input  logic                      mul_done,
    output logic                      mul_rst
);

    localparam int         IDX_W    = $clog2(N_REQ);
    localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT);

    arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  w_idx;
    logic [N_REQ-1:0]  w_onehot;
    logic [9:0]        wd_cnt;
    logic              err_q;

    logic [N_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [FP32_W-1:0] sel_op1;
    logic [FP32_W-1:0] sel_op2;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        sel_op1 = '0;
        sel_op2 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_op1 = op1_in[i*FP32_W +: FP32_W];
                sel_op2 = op2_in[i*FP32_W +: FP32_W];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt        = '0;
        resp_valid = '0;
        resp_err   = 1'b0;
        mul_ready  = 1'b0;
        mul_rst    = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                gnt       = w_onehot;
                mul_ready = 1'b1;
                state_nxt = ST_WAIT;
            end
            // A completion in the timeout cycle still counts as a good result.
            ST_WAIT: begin
                if (mul_done) begin
                    state_nxt = ST_RESP;
                end else if (wd_cnt == WD_LIMIT) begin
                    state_nxt = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                mul_rst   = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = w_onehot;
                resp_err   = err_q;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            w_idx    <= '0;
            w_onehot <= '0;
            wd_cnt   <= '0;
            err_q    <= 1'b0;
            mul_op1  <= '0;
            mul_op2  <= '0;
            resp_res <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (pick_any) begin
                        w_idx    <= pick_idx;
                        w_onehot <= pick_onehot;
                        mul_op1  <= sel_op1;
                        mul_op2  <= sel_op2;
                        err_q    <= 1'b0;
                    end
                end
                // wd_cnt equals the number of the current WAIT cycle, starting at 1.
                ST_ISSUE: begin
                    wd_cnt <= 10'd1;
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        resp_res <= mul_res;
                        err_q    <= 1'b0;
                    end else if (wd_cnt == WD_LIMIT) begin
                        resp_res <= QNAN_VAL;
                        err_q    <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 10'd1;
                    end
                end
                ST_RESP: begin
                    rr_ptr <= (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_rr_arbiter.sv
// tb/tb_fpmul_rr_arbiter.sv - directed self-checking bench for fpmul_rr_arbiter
module tb_fpmul_rr_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [127:0] op1_in = '0;
    logic [127:0] op2_in = '0;
    logic [N-1:0] gnt;
    logic [N-1:0] resp_valid;
    logic [31:0]  resp_res;
    logic         resp_err;
    logic         busy;
    logic         mul_ready;
    logic [31:0]  mul_op1;
    logic [31:0]  mul_op2;
    logic [31:0]  mul_res = 32'hDEAD_BEEF;
    logic         mul_done = 1'b0;
    logic         mul_rst;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_cnt = 0;
    int rst_cnt = 0;
    int resp_cnt = 0;

    int          stub_mode = 0;
    int          stub_lat = 2;
    logic [31:0] stub_fixed = 32'h0;
    int          stub_left = 0;
    logic        stub_pend = 1'b0;
    logic [31:0] stub_val = 32'h0;

    fpmul_rr_arbiter #(
        .N_REQ    (N),
        .TIMEOUT  (TO),
        .QNAN_VAL (32'h7FC0_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .op1_in     (op1_in),
        .op2_in     (op2_in),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_res   (resp_res),
        .resp_err   (resp_err),
        .busy       (busy),
        .mul_ready  (mul_ready),
        .mul_op1    (mul_op1),
        .mul_op2    (mul_op2),
        .mul_res    (mul_res),
        .mul_done   (mul_done),
        .mul_rst    (mul_rst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [24:0] m;
        logic        g;
        logic        st;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e++;
            m  = {1'b0, p[47:24]};
            g  = p[23];
            st = |p[22:0];
        end else begin
            m  = {1'b0, p[46:23]};
            g  = p[22];
            st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        return {s, 8'(e), m[22:0]};
    endfunction

    // Multiplier model: mode 0 real result, 1 never completes, 2 fixed result.
    always @(negedge clk) begin
        mul_done = 1'b0;
        if (mul_rst) begin
            stub_pend = 1'b0;
        end else if (mul_ready) begin
            stub_pend = (stub_mode != 1);
            stub_left = stub_lat;
            stub_val  = (stub_mode == 2) ? stub_fixed : fpmul(mul_op1, mul_op2);
        end else if (stub_pend) begin
            stub_left--;
            if (stub_left == 0) begin
                stub_pend = 1'b0;
                mul_done  = 1'b1;
                mul_res   = stub_val;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mul_ready) ready_cnt++;
        if (mul_rst) rst_cnt++;
        if (|resp_valid) resp_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
        ready_cnt = 0;
        rst_cnt = 0;
        resp_cnt = 0;
    endtask

    task automatic wait_resp(input int max, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            n++;
            if (|resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        op1_in = {4{32'h3F80_0000}};
        op2_in = {4{32'h3F80_0000}};
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || mul_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl gnt=%b busy=%b mul_ready=%b exp 0000 0 0", gnt, busy, mul_ready);
        end
        checks++;
        if (resp_valid !== 4'b0000 || resp_err !== 1'b0 || mul_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp resp_valid=%b resp_err=%b mul_rst=%b exp 0000 0 0", resp_valid, resp_err, mul_rst);
        end
        checks++;
        if (resp_res !== 32'h0 || mul_op1 !== 32'h0 || mul_op2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_data resp_res=%h mul_op1=%h mul_op2=%h exp 0", resp_res, mul_op1, mul_op2);
        end
        req = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        bit ok;
        do_reset();
        stub_mode = 0;
        stub_lat = 2;
        op1_in[31:0] = 32'h3FC0_0000;
        op2_in[31:0] = 32'h4000_0000;
        req = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0001 || mul_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt gnt=%b mul_ready=%b exp 0001 1", gnt, mul_ready);
        end
        checks++;
        if (mul_op1 !== 32'h3FC0_0000 || mul_op2 !== 32'h4000_0000) begin
            errors++;
            $display("FAIL single_ops mul_op1=%h mul_op2=%h exp 3fc00000 40000000", mul_op1, mul_op2);
        end
        tick();
        req = '0;
        wait_resp(20, n, ok);
        checks++;
        if (!ok || (n + 1) != stub_lat + 1) begin
            errors++;
            $display("FAIL single_latency got_resp=%0d cycles=%0d exp 1 %0d", ok, n + 1, stub_lat + 1);
        end
        checks++;
        if (resp_valid !== 4'b0001 || resp_res !== 32'h4040_0000 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_resp valid=%b res=%h err=%b exp 0001 40400000 0", resp_valid, resp_res, resp_err);
        end
        tick();
        checks++;
        if (ready_cnt != 1 || busy !== 1'b0 || resp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL single_after ready_cnt=%0d busy=%b valid=%b exp 1 0 0000", ready_cnt, busy, resp_valid);
        end
    endtask

    task automatic test_all_four();
        logic [3:0]  gq[$];
        logic [3:0]  vq[$];
        logic [31:0] rq[$];
        logic        eq[$];
        int          order[5];
        logic [31:0] exp_res[4];
        logic [3:0]  eg;
        order   = '{0, 1, 2, 3, 0};
        exp_res = '{32'h40C0_0000, 32'h4010_0000, 32'h4000_0000, 32'hC120_0000};
        do_reset();
        stub_mode = 0;
        stub_lat = 1;
        op1_in = {32'hC000_0000, 32'h4080_0000, 32'h3FC0_0000, 32'h4000_0000};
        op2_in = {32'h40A0_0000, 32'h3F00_0000, 32'h3FC0_0000, 32'h4040_0000};
        req = 4'b1111;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (|gnt) gq.push_back(gnt);
            if (|resp_valid) begin
                vq.push_back(resp_valid);
                rq.push_back(resp_res);
                eq.push_back(resp_err);
            end
            if (vq.size() == 5) begin
                req = '0;
                break;
            end
        end
        checks++;
        if (gq.size() != 5 || vq.size() != 5) begin
            errors++;
            $display("FAIL all4_count grants=%0d resps=%0d exp 5 5", gq.size(), vq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                eg = 4'b0001 << order[i];
                checks++;
                if (gq[i] !== eg || vq[i] !== eg) begin
                    errors++;
                    $display("FAIL all4_order[%0d] gnt=%b valid=%b exp %b", i, gq[i], vq[i], eg);
                end
                checks++;
                if (rq[i] !== exp_res[order[i]] || eq[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL all4_res[%0d] res=%h err=%b exp %h 0", i, rq[i], eq[i], exp_res[order[i]]);
                end
            end
        end
        tick();
        checks++;
        if (ready_cnt != 5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL all4_idle ready_cnt=%0d busy=%b exp 5 0", ready_cnt, busy);
        end
    endtask

    task automatic test_rr_pointer();
        logic [3:0] gq[$];
        int         nresp;
        bit         ok;
        int         n;
        do_reset();
        stub_mode = 0;
        stub_lat = 1;
        op1_in = {32'h0, 32'h4080_0000, 32'h0, 32'h4000_0000};
        op2_in = {32'h0, 32'h3F00_0000, 32'h0, 32'h4040_0000};
        req = 4'b0100;
        wait_resp(20, n, ok);
        checks++;
        if (!ok || resp_valid !== 4'b0100 || resp_res !== 32'h4000_0000) begin
            errors++;
            $display("FAIL rr_first ok=%0d valid=%b res=%h exp 1 0100 40000000", ok, resp_valid, resp_res);
        end
        req = 4'b0101;
        nresp = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (|gnt) gq.push_back(gnt);
            if (|resp_valid) nresp++;
            if (nresp == 2) begin
                req = '0;
                break;
            end
        end
        checks++;
        if (gq.size() != 2) begin
            errors++;
            $display("FAIL rr_count grants=%0d exp 2", gq.size());
        end else begin
            checks++;
            if (gq[0] !== 4'b0001 || gq[1] !== 4'b0100) begin
                errors++;
                $display("FAIL rr_order got %b,%b exp 0001,0100", gq[0], gq[1]);
            end
        end
        tick();
    endtask

    task automatic test_watchdog();
        int  issue_cyc;
        int  rst_at;
        int  n;
        bit  ok;
        do_reset();
        stub_mode = 1;
        stub_lat = 2;
        op1_in[63:32] = 32'h4000_0000;
        op2_in[63:32] = 32'h4000_0000;
        req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL wd_gnt gnt=%b exp 0010", gnt);
        end
        req = '0;
        issue_cyc = cyc;
        rst_at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mul_rst) begin
                rst_at = cyc - issue_cyc;
                break;
            end
        end
        checks++;
        if (rst_at != TO + 1) begin
            errors++;
            $display("FAIL wd_rst_time offset=%0d exp %0d", rst_at, TO + 1);
        end
        tick();
        checks++;
        if (resp_valid !== 4'b0010 || resp_err !== 1'b1 || resp_res !== 32'h7FC0_0000) begin
            errors++;
            $display("FAIL wd_resp valid=%b err=%b res=%h exp 0010 1 7fc00000", resp_valid, resp_err, resp_res);
        end
        checks++;
        if (rst_cnt != 1 || mul_rst !== 1'b0) begin
            errors++;
            $display("FAIL wd_rst_pulse count=%0d now=%b exp 1 0", rst_cnt, mul_rst);
        end
        stub_mode = 0;
        tick();
        req = 4'b0010;
        wait_resp(20, n, ok);
        req = '0;
        checks++;
        if (!ok || resp_valid !== 4'b0010 || resp_err !== 1'b0 || resp_res !== 32'h4080_0000) begin
            errors++;
            $display("FAIL wd_next ok=%0d valid=%b err=%b res=%h exp 1 0010 0 40800000", ok, resp_valid, resp_err, resp_res);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit busy_seen;
        do_reset();
        stub_mode = 0;
        stub_lat = 5;
        op1_in[31:0] = 32'h4000_0000;
        op2_in[31:0] = 32'h4000_0000;
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0 || resp_valid !== 4'b0 || mul_ready !== 1'b0 || mul_rst !== 1'b0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ctrl busy=%b gnt=%b valid=%b ready=%b mrst=%b err=%b exp all 0",
                     busy, gnt, resp_valid, mul_ready, mul_rst, resp_err);
        end
        checks++;
        if (mul_op1 !== 32'h0 || mul_op2 !== 32'h0 || resp_res !== 32'h0) begin
            errors++;
            $display("FAIL midrst_data op1=%h op2=%h res=%h exp 0", mul_op1, mul_op2, resp_res);
        end
        rst = 1'b0;
        resp_cnt = 0;
        ready_cnt = 0;
        busy_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy) busy_seen = 1'b1;
        end
        checks++;
        if (resp_cnt != 0 || busy_seen || ready_cnt != 0) begin
            errors++;
            $display("FAIL midrst_stale resps=%0d busy_seen=%0d readies=%0d exp 0 0 0", resp_cnt, busy_seen, ready_cnt);
        end
    endtask

    task automatic test_done_at_timeout();
        int n;
        bit ok;
        do_reset();
        stub_mode = 2;
        stub_lat = TO;
        stub_fixed = 32'h1234_5678;
        op1_in[127:96] = 32'h3F80_0000;
        op2_in[127:96] = 32'h3F80_0000;
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL tie_gnt gnt=%b exp 1000", gnt);
        end
        req = '0;
        wait_resp(30, n, ok);
        checks++;
        if (!ok || n != TO + 1) begin
            errors++;
            $display("FAIL tie_latency ok=%0d cycles=%0d exp 1 %0d", ok, n, TO + 1);
        end
        checks++;
        if (resp_valid !== 4'b1000 || resp_err !== 1'b0 || resp_res !== 32'h1234_5678 || rst_cnt != 0) begin
            errors++;
            $display("FAIL tie_resp valid=%b err=%b res=%h mul_rst_cnt=%0d exp 1000 0 12345678 0",
                     resp_valid, resp_err, resp_res, rst_cnt);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_rr_pointer();
        test_watchdog();
        test_reset_mid();
        test_done_at_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t exp finish before 500000", $time);
        $fatal(1, "bench time limit");
    end

endmodule
